lzw_backward_decompress: RTL and testbench

Receive-side LZW decoder. It consumes the 14-bit code stream and resolves each code into its byte string by walking the prefix chain in `lzw_backward_dictionary`. Bytes come off the chain in reverse order, so the block buffers them on a LIFO and emits them in forward order with valid/ready backpressure. It sits between the code deframer and the byte sink, and is the only reader of the dictionary consult port.

---
 rtl/lzw_pkg.sv | 20 ++
 rtl/lzw_backward_decompress_stack.sv | 43 ++++
 rtl/lzw_backward_decompress.sv | 132 +++++++++++++
 tb/tb_lzw_backward_decompress.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lzw_pkg.sv
// Shared constants and FSM encoding for the LZW backward decompressor.
package lzw_pkg;
  localparam int LZW_CODE_W = 14;
  localparam logic [LZW_CODE_W-1:0] LZW_LIT_MAX = 14'h0FF;

  localparam int DICT_W          = 23;
  localparam int DICT_VALID_BIT  = 22;
  localparam int DICT_PREFIX_MSB = 21;
  localparam int DICT_PREFIX_LSB = 8;
  localparam int DICT_BYTE_MSB   = 7;
  localparam int DICT_BYTE_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT,
    ST_POP,
    ST_ERR
  } lzw_state_t;
endpackage

// File: rtl/lzw_backward_decompress_stack.sv
// Byte LIFO that reverses the prefix-chain walk; can take one or two bytes per push.
module lzw_byte_stack #(
  parameter int STACK_DEPTH = 1024
) (
  input  logic                             I_sys_clk,
  input  logic                             I_sys_rst,
  input  logic                             push,
  input  logic                             push_two,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [7:0]                       din,
  input  logic [7:0]                       din2,
  output logic [7:0]                       top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] count,
  output logic                             full,
  output logic                             empty
);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [7:0]       mem [STACK_DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr1, rd_ptr;

  assign wr_ptr  = PTR_W'(count);
  assign wr_ptr1 = wr_ptr + PTR_W'(1);
  assign rd_ptr  = PTR_W'(count - CNT_W'(1));
  assign full    = (count == CNT_W'(STACK_DEPTH));
  assign empty   = (count == '0);
  assign top     = empty ? 8'h00 : mem[rd_ptr];

  // push_two lands din below din2, so din2 becomes the new top
  always_ff @(posedge I_sys_clk) begin
    if (push || push_two) mem[wr_ptr] <= din;
    if (push_two)         mem[wr_ptr1] <= din2;
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst || flush) count <= '0;
    else if (push_two)      count <= count + CNT_W'(2);
    else if (push)          count <= count + CNT_W'(1);
    else if (pop)           count <= count - CNT_W'(1);
  end
endmodule

// File: rtl/lzw_backward_decompress.sv
// LZW decoder: walks the dictionary prefix chain, stacks bytes, emits them in forward order.
module lzw_backward_decompress
  import lzw_pkg::*;
#(
  parameter int DICT_RD_LAT = 2,
  parameter int STACK_DEPTH = 1024
) (
  input  logic                  I_sys_clk,
  input  logic                  I_sys_rst,
  input  logic                  I_state_clr,
  input  logic [LZW_CODE_W-1:0] I_code,
  input  logic                  I_code_valid,
  input  logic                  I_code_last,
  output logic                  O_code_ready,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_data_last,
  input  logic                  I_data_ready,
  output logic [LZW_CODE_W-1:0] O_dictionary_addr,
  input  logic [DICT_W-1:0]     I_dictionary_dout,
  output logic [31:0]           O_code_cnt,
  output logic [31:0]           O_byte_cnt,
  output logic [15:0]           O_err_cnt
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int LAT_W = $clog2(DICT_RD_LAT + 1);

  lzw_state_t            state_q, state_d;
  logic                  accept, is_lit, sample, last_q;
  logic                  ent_vld, pfx_lit, room1, room2;
  logic [LZW_CODE_W-1:0] ent_pfx;
  logic [7:0]            ent_byte;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  push, push_two, pop, flush, full, empty;
  logic [7:0]            din, din2, top;
  logic [CNT_W-1:0]      count;

  assign O_code_ready = (state_q == ST_IDLE) && !I_sys_rst;
  assign O_data_valid = (state_q == ST_POP) && !empty && !I_sys_rst;
  assign accept       = I_code_valid && O_code_ready;
  assign is_lit       = (I_code <= LZW_LIT_MAX);

  assign ent_vld  = I_dictionary_dout[DICT_VALID_BIT];
  assign ent_pfx  = I_dictionary_dout[DICT_PREFIX_MSB:DICT_PREFIX_LSB];
  assign ent_byte = I_dictionary_dout[DICT_BYTE_MSB:DICT_BYTE_LSB];
  assign pfx_lit  = (ent_pfx <= LZW_LIT_MAX);
  // dout is only trusted on the terminal latency count of the held address
  assign sample   = (state_q == ST_WAIT) && (lat_cnt == LAT_W'(DICT_RD_LAT));
  assign room1    = !full;
  assign room2    = (int'(count) + 2) <= STACK_DEPTH;

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = is_lit ? ST_POP : ST_LOOKUP;
      ST_LOOKUP: state_d = ST_WAIT;
      ST_WAIT:
        if (sample) begin
          if (!ent_vld)     state_d = ST_ERR;
          else if (pfx_lit) state_d = room2 ? ST_POP : ST_ERR;
          else              state_d = room1 ? ST_LOOKUP : ST_ERR;
        end
      ST_POP:    if (pop && count == CNT_W'(1)) state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push        = 1'b0;
    push_two    = 1'b0;
    din         = ent_byte;
    din2        = ent_pfx[7:0];
    pop         = O_data_valid && I_data_ready;
    flush       = (state_q == ST_ERR);
    O_data      = O_data_valid ? top : 8'h00;
    O_data_last = O_data_valid && last_q && (count == CNT_W'(1));
    if (state_q == ST_IDLE && accept && is_lit) begin
      push = 1'b1;
      din  = I_code[7:0];
    end else if (sample && ent_vld) begin
      push     = !pfx_lit && room1;
      push_two = pfx_lit && room2;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      O_dictionary_addr <= '0;
      lat_cnt           <= '0;
      last_q            <= 1'b0;
    end else begin
      if (accept) last_q <= I_code_last;
      if (state_q == ST_IDLE && accept && !is_lit) O_dictionary_addr <= I_code;
      else if (sample && ent_vld && !pfx_lit)      O_dictionary_addr <= ent_pfx;
      if (state_q == ST_LOOKUP)    lat_cnt <= LAT_W'(1);
      else if (state_q == ST_WAIT) lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst || I_state_clr) begin
      O_code_cnt <= '0;
      O_byte_cnt <= '0;
      O_err_cnt  <= '0;
    end else begin
      if (accept) O_code_cnt <= O_code_cnt + 32'd1;
      if (pop)    O_byte_cnt <= O_byte_cnt + 32'd1;
      if (state_q == ST_ERR && O_err_cnt != 16'hFFFF) O_err_cnt <= O_err_cnt + 16'd1;
    end
  end

  lzw_byte_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .I_sys_clk (I_sys_clk),
    .I_sys_rst (I_sys_rst),
    .push      (push),
    .push_two  (push_two),
    .pop       (pop),
    .flush     (flush),
    .din       (din),
    .din2      (din2),
    .top       (top),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );
endmodule

// File: tb/tb_lzw_backward_decompress.sv
// Directed bench: literal, chains, backpressure, undefined and looping codes, reset and clear.
module tb_lzw_backward_decompress;
  localparam int LAT = 2;

  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [13:0] code = '0;
  logic        code_valid = 1'b0, code_last = 1'b0, data_ready;
  logic        code_ready, data_valid, data_last;
  logic [7:0]  data;
  logic [13:0] dict_addr;
  logic [22:0] dict_dout;
  logic [31:0] code_cnt, byte_cnt;
  logic [15:0] err_cnt;

  logic [22:0] dict_mem [16384];
  logic [13:0] a_pipe [LAT];
  logic [7:0]  bq [$];
  logic        lq [$];
  int          cq [$];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, stab_err = 0, hold_cnt = 0;
  int rdy_mode = 0, ic = 0;
  logic       hold_v = 1'b0, hold_l = 1'b0;
  logic [7:0] hold_d = '0;

  lzw_backward_decompress #(.DICT_RD_LAT(LAT), .STACK_DEPTH(4)) dut (
    .I_sys_clk(clk), .I_sys_rst(rst), .I_state_clr(clr),
    .I_code(code), .I_code_valid(code_valid), .I_code_last(code_last),
    .O_code_ready(code_ready), .O_data(data), .O_data_valid(data_valid),
    .O_data_last(data_last), .I_data_ready(data_ready),
    .O_dictionary_addr(dict_addr), .I_dictionary_dout(dict_dout),
    .O_code_cnt(code_cnt), .O_byte_cnt(byte_cnt), .O_err_cnt(err_cnt)
  );

  initial forever #2 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // dictionary read model: address to data in LAT clock edges
  initial begin
    for (int i = 0; i < LAT; i++) a_pipe[i] = '0;
    forever begin
      @(posedge clk);
      a_pipe[0] <= dict_addr;
      for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
  end
  assign dict_dout = dict_mem[a_pipe[LAT-1]];

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode != 0) data_ready = ~data_ready;
      else               data_ready = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (code_valid && code_ready) acc_cyc = cyc;
    if (data_valid && data_ready) begin
      bq.push_back(data); lq.push_back(data_last); cq.push_back(cyc);
    end
    if (hold_v) begin
      hold_cnt++;
      if (!data_valid || data !== hold_d || data_last !== hold_l) stab_err++;
    end
    hold_v = data_valid && !data_ready;
    hold_d = data;
    hold_l = data_last;
  end

  initial begin
    #40000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] ent(input logic [13:0] p, input logic [7:0] b);
    return {1'b1, p, b};
  endfunction

  task automatic clear_q();
    bq.delete(); lq.delete(); cq.delete();
  endtask

  task automatic send_code(input logic [13:0] c, input logic l);
    int n = 0;
    @(posedge clk); #1;
    code = c; code_last = l; code_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!code_ready && n < 50);
    chk("accept", code_ready, 1);
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    do begin @(negedge clk); n++; end while (!code_ready && n < 100);
    chk("idle_timeout", code_ready, 1);
    c = cyc;
  endtask

  task automatic expect_bytes(input string tag, input int n, input logic [23:0] s);
    chk({tag, "_n"}, bq.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_byte"}, bq[i], s[8*(n-1-i) +: 8]);
      chk({tag, "_last"}, lq[i], (i == n-1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, code_ready, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_last"}, data_last, 0);
    chk({tag, "_addr"}, dict_addr, 0);
    chk({tag, "_ccnt"}, code_cnt, 0);
    chk({tag, "_bcnt"}, byte_cnt, 0);
    chk({tag, "_ecnt"}, err_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) dict_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", code_ready, 1);

    // literal: byte one cycle after accept, ready again two after
    clear_q();
    send_code(14'h041, 1'b1);
    wait_idle(ic);
    expect_bytes("lit", 1, 24'h000041);
    chk("lit_lat", cq[0] - acc_cyc, 1);
    chk("lit_ready", ic - acc_cyc, 2);
    chk("lit_ccnt", code_cnt, 1);
    chk("lit_bcnt", byte_cnt, 1);

    // two-entry chain: 6 idle cycles between accept and first byte
    dict_mem[14'h100] = ent(14'h061, 8'h62);
    dict_mem[14'h102] = ent(14'h100, 8'h63);
    clear_q();
    send_code(14'h102, 1'b1);
    wait_idle(ic);
    expect_bytes("chain", 3, 24'h616263);
    chk("chain_lat", cq[0] - acc_cyc, 1 + 2*(LAT+1));
    chk("chain_gap1", cq[1] - cq[0], 1);
    chk("chain_gap2", cq[2] - cq[1], 1);
    chk("chain_ccnt", code_cnt, 2);
    chk("chain_bcnt", byte_cnt, 4);

    // same chain under alternating backpressure
    clear_q(); stab_err = 0; hold_cnt = 0; rdy_mode = 1;
    send_code(14'h102, 1'b1);
    wait_idle(ic);
    rdy_mode = 0;
    expect_bytes("tog", 3, 24'h616263);
    chk("tog_stable", stab_err, 0);
    chk("tog_held", hold_cnt > 0, 1);
    chk("tog_ready_after_c", ic - cq[2], 1);

    // undefined entry errors out, next literal is fine
    clear_q();
    send_code(14'h1FF, 1'b1);
    wait_idle(ic);
    chk("undef_n", bq.size(), 0);
    chk("undef_ecnt", err_cnt, 1);
    send_code(14'h07A, 1'b1);
    wait_idle(ic);
    expect_bytes("after_err", 1, 24'h00007A);

    // self-referencing entry overflows the 4-deep stack
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    chk("clr_ecnt", err_cnt, 0);
    chk("clr_ccnt", code_cnt, 0);
    dict_mem[14'h100] = ent(14'h100, 8'h78);
    clear_q();
    send_code(14'h100, 1'b1);
    wait_idle(ic);
    chk("loop_n", bq.size(), 0);
    chk("loop_ecnt", err_cnt, 1);
    chk("loop_lat", ic - acc_cyc, 5*(LAT+1) + 2);

    // saturation of the error counter
    @(posedge clk); #1; force dut.O_err_cnt = 16'hFFFF;
    @(posedge clk); #1; release dut.O_err_cnt;
    @(negedge clk);
    chk("err_forced", err_cnt, 16'hFFFF);
    send_code(14'h1FF, 1'b1);
    wait_idle(ic);
    chk("err_sat", err_cnt, 16'hFFFF);

    // reset while waiting on the dictionary
    dict_mem[14'h100] = ent(14'h061, 8'h62);
    send_code(14'h102, 1'b1);
    @(posedge clk); #1; rst = 1'b1;
    clear_q();
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", code_ready, 1);
    repeat (12) @(negedge clk);
    chk("midrst_nobytes", bq.size(), 0);
    clear_q();
    send_code(14'h102, 1'b1);
    wait_idle(ic);
    expect_bytes("postrst", 3, 24'h616263);

    // clear in the same cycle as an accept wins over the increment
    @(posedge clk); #1;
    code = 14'h041; code_last = 1'b1; code_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    chk("clracc_ready", code_ready, 1);
    @(posedge clk); #1;
    code_valid = 1'b0; clr = 1'b0;
    wait_idle(ic);
    chk("clracc_ccnt", code_cnt, 0);
    chk("clracc_bcnt", byte_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
